// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - per-pin GPIO pad drive, input synchronizer, debounce and edge interrupts
module gpio_ctrl #(
  parameter int N   = 8,
  parameter int DBW = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   out_val,
  input  logic [N-1:0]   out_en,
  input  logic [N-1:0]   in_en,
  input  logic [N-1:0]   pull_up,
  input  logic [N-1:0]   pull_down,
  input  logic [DBW-1:0] db_len,
  input  logic [N-1:0]   irq_rise_en,
  input  logic [N-1:0]   irq_fall_en,
  input  logic [N-1:0]   irq_clr,
  output logic [N-1:0]   in_val,
  output logic [N-1:0]   irq_pend,
  output logic           irq,
  output logic [N-1:0]   pad_di,
  output logic [N-1:0]   pad_oe,
  output logic [N-1:0]   pad_ie,
  output logic [N-1:0]   pad_pu,
  output logic [N-1:0]   pad_pd,
  input  logic [N-1:0]   pad_dc
);

  logic [N-1:0]          di_q, di_d;
  logic [N-1:0]          oe_q, oe_d;
  logic [N-1:0]          ie_q, ie_d;
  logic [N-1:0]          pu_q, pu_d;
  logic [N-1:0]          pd_q, pd_d;
  logic [N-1:0]          s1_q, s1_d;
  logic [N-1:0]          s2_q, s2_d;
  logic [N-1:0]          stable_q, stable_d;
  logic [N-1:0]          pend_q, pend_d;
  logic [N-1:0][DBW-1:0] cnt_q, cnt_d;
  logic [N-1:0]          rise, fall;

  always_comb begin
    di_d     = out_val;
    oe_d     = out_en;
    ie_d     = in_en;
    pu_d     = pull_up;
    pd_d     = pull_down & ~pull_up;
    s1_d     = s1_q;
    s2_d     = s2_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < N; i++) begin
      // A disabled input freezes the synchronizer so X/Z from the pad never reaches it.
      if (in_en[i]) begin
        s1_d[i] = pad_dc[i];
        s2_d[i] = s1_q[i];
        if (s2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= db_len) begin
          stable_d[i] = s2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DBW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign rise   = stable_d & ~stable_q;
  assign fall   = ~stable_d & stable_q;
  // Set terms are ORed after the clear so a same-cycle edge wins.
  assign pend_d = (pend_q & ~irq_clr) | (rise & irq_rise_en) | (fall & irq_fall_en);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      di_q     <= '0;
      oe_q     <= '0;
      ie_q     <= '0;
      pu_q     <= '0;
      pd_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
    end else begin
      di_q     <= di_d;
      oe_q     <= oe_d;
      ie_q     <= ie_d;
      pu_q     <= pu_d;
      pd_q     <= pd_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pad_di   = di_q;
  assign pad_oe   = oe_q;
  assign pad_ie   = ie_q;
  assign pad_pu   = pu_q;
  assign pad_pd   = pd_q;
  assign in_val   = stable_q;
  assign irq_pend = pend_q;
  assign irq      = |pend_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed and randomized checks of gpio_ctrl against a behavioural model
module tb_gpio_ctrl;
  localparam int N   = 8;
  localparam int DBW = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   out_val, out_en, in_en, pull_up, pull_down;
  logic [DBW-1:0] db_len;
  logic [N-1:0]   irq_rise_en, irq_fall_en, irq_clr;
  logic [N-1:0]   in_val, irq_pend;
  logic           irq;
  logic [N-1:0]   pad_di, pad_oe, pad_ie, pad_pu, pad_pd, pad_dc;

  int total = 0;
  int bad   = 0;

  // Model: pad image, two-stage sample delay, debounced level, consecutive-disagreement run.
  logic [N-1:0] m_di, m_oe, m_ie, m_pu, m_pd, m_d0, m_d1, m_lvl, m_pend;
  int           m_run [N];

  gpio_ctrl #(.N(N), .DBW(DBW)) dut (
    .clk(clk), .rstn(rstn), .out_val(out_val), .out_en(out_en), .in_en(in_en),
    .pull_up(pull_up), .pull_down(pull_down), .db_len(db_len),
    .irq_rise_en(irq_rise_en), .irq_fall_en(irq_fall_en), .irq_clr(irq_clr),
    .in_val(in_val), .irq_pend(irq_pend), .irq(irq),
    .pad_di(pad_di), .pad_oe(pad_oe), .pad_ie(pad_ie), .pad_pu(pad_pu), .pad_pd(pad_pd),
    .pad_dc(pad_dc)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    {m_di, m_oe, m_ie, m_pu, m_pd, m_d0, m_d1, m_lvl, m_pend} = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  // One clock edge; the model consumes the inputs that were present before the edge.
  task automatic tick();
    logic [N-1:0] c_ov, c_oe, c_ie, c_pu, c_pd, c_re, c_fe, c_clr, c_dc;
    int c_db;
    logic c_rstn, lvl_new;
    c_ov = out_val; c_oe = out_en; c_ie = in_en; c_pu = pull_up; c_pd = pull_down;
    c_re = irq_rise_en; c_fe = irq_fall_en; c_clr = irq_clr; c_dc = pad_dc;
    c_db = int'(db_len); c_rstn = rstn;
    @(posedge clk);
    if (!c_rstn) begin
      model_clear();
    end else begin
      m_di = c_ov; m_oe = c_oe; m_ie = c_ie; m_pu = c_pu;
      m_pd = c_pd & ~c_pu;
      for (int i = 0; i < N; i++) begin
        lvl_new = m_lvl[i];
        if (c_ie[i]) begin
          if (m_d1[i] != m_lvl[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] > c_db) begin
              lvl_new  = m_d1[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
          m_d1[i] = m_d0[i];
          m_d0[i] = c_dc[i];
        end else begin
          m_run[i] = 0;
        end
        if (c_clr[i]) m_pend[i] = 1'b0;
        if (lvl_new && !m_lvl[i] && c_re[i]) m_pend[i] = 1'b1;
        if (!lvl_new && m_lvl[i] && c_fe[i]) m_pend[i] = 1'b1;
        m_lvl[i] = lvl_new;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    out_val = '0; out_en = '0; in_en = '0; pull_up = '0; pull_down = '0;
    db_len = '0; irq_rise_en = '0; irq_fall_en = '0; irq_clr = '0; pad_dc = '0;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    out_val = '1; out_en = '1; in_en = '1; pull_up = '1; pull_down = '1;
    db_len = '1; irq_rise_en = '1; irq_fall_en = '1; irq_clr = '1; pad_dc = '1;
    #3;
    total++;
    if ({pad_di, pad_oe, pad_ie, pad_pu, pad_pd, in_val, irq_pend, irq} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got di=%h oe=%h ie=%h pu=%h pd=%h in=%h pend=%h irq=%b, want all 0",
               pad_di, pad_oe, pad_ie, pad_pu, pad_pd, in_val, irq_pend, irq);
    end
    tick();
    model_clear();
    rstn = 1'b1;
    tick();
    total++;
    if ({pad_oe, pad_di, pad_ie, pad_pu, pad_pd} !== {{4*N{1'b1}}, {N{1'b0}}}) begin
      bad++;
      $display("FAIL reset_release_pads: got oe=%h di=%h ie=%h pu=%h pd=%h, want ff ff ff ff 00",
               pad_oe, pad_di, pad_ie, pad_pu, pad_pd);
    end
    total++;
    if (in_val !== '0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_in: got in_val=%h irq=%b, want 00 0", in_val, irq);
    end
  endtask

  task automatic test_pull_drive();
    apply_reset();
    pull_up = '1; pull_down = '1;
    tick();
    total++;
    if (pad_pu !== 8'hff || pad_pd !== 8'h00) begin
      bad++;
      $display("FAIL pull_conflict: got pu=%h pd=%h, want ff 00", pad_pu, pad_pd);
    end
    pull_up = '0;
    total++;
    if (pad_pd !== 8'h00) begin
      bad++;
      $display("FAIL pull_down_early: got pd=%h before edge, want 00", pad_pd);
    end
    tick();
    total++;
    if (pad_pu !== 8'h00 || pad_pd !== 8'hff) begin
      bad++;
      $display("FAIL pull_down: got pu=%h pd=%h, want 00 ff", pad_pu, pad_pd);
    end
    for (int k = 0; k < 4; k++) begin
      logic [N-1:0] prev, v;
      prev = out_val;
      v = N'($urandom);
      out_val = v;
      total++;
      if (pad_di !== prev) begin
        bad++;
        $display("FAIL drive_hold: got di=%h before edge, want %h", pad_di, prev);
      end
      tick();
      total++;
      if (pad_di !== v) begin
        bad++;
        $display("FAIL drive_follow: got di=%h, want %h", pad_di, v);
      end
    end
  endtask

  task automatic test_debounce();
    int edges;
    apply_reset();
    db_len = 8'd4; in_en = '1; irq_rise_en = 8'h01;
    tick();
    pad_dc[0] = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    pad_dc[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (in_val[0] !== 1'b0 || irq !== 1'b0) begin
        bad++;
        $display("FAIL debounce_glitch: cycle %0d got in_val0=%b irq=%b, want 0 0", k, in_val[0], irq);
      end
    end
    pad_dc[0] = 1'b1;
    edges = 0;
    while (in_val[0] !== 1'b1 && edges < 30) begin
      tick();
      edges++;
    end
    total++;
    if (edges != 7) begin
      bad++;
      $display("FAIL debounce_latency: got %0d edges, want 7", edges);
    end
    total++;
    if (irq_pend[0] !== 1'b1 || irq !== 1'b1) begin
      bad++;
      $display("FAIL debounce_irq: got pend0=%b irq=%b, want 1 1", irq_pend[0], irq);
    end
  endtask

  task automatic test_db_zero();
    logic exp_seq [6];
    exp_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    apply_reset();
    db_len = 8'd0; in_en = '1;
    tick();
    pad_dc[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) pad_dc[1] = 1'b0;
      total++;
      if (in_val[1] !== exp_seq[k]) begin
        bad++;
        $display("FAIL db_zero_pulse: edge %0d got in_val1=%b, want %b", k + 1, in_val[1], exp_seq[k]);
      end
    end
  endtask

  task automatic test_irq_clear();
    apply_reset();
    db_len = 8'd0; in_en = '1; irq_rise_en = 8'h04; irq_fall_en = 8'h04;
    pad_dc[2] = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    total++;
    if (irq_pend !== 8'h04 || irq !== 1'b1) begin
      bad++;
      $display("FAIL clr_setup: got pend=%h irq=%b, want 04 1", irq_pend, irq);
    end
    irq_clr[2] = 1'b1;
    tick();
    irq_clr[2] = 1'b0;
    total++;
    if (irq_pend[2] !== 1'b0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL clr_pulse: got pend2=%b irq=%b, want 0 0", irq_pend[2], irq);
    end
    pad_dc[2] = 1'b0;
    tick();
    tick();
    irq_clr[2] = 1'b1;
    tick();
    irq_clr[2] = 1'b0;
    total++;
    if (irq_pend[2] !== 1'b1 || in_val[2] !== 1'b0 || irq !== 1'b1) begin
      bad++;
      $display("FAIL clr_set_wins: got pend2=%b in_val2=%b irq=%b, want 1 0 1", irq_pend[2], in_val[2], irq);
    end
  endtask

  task automatic test_in_disable();
    int edges;
    apply_reset();
    db_len = 8'd2; in_en = '1; irq_fall_en = 8'h08; irq_rise_en = 8'h08;
    pad_dc[3] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    irq_clr = '1;
    tick();
    irq_clr = '0;
    total++;
    if (in_val[3] !== 1'b1 || irq !== 1'b0) begin
      bad++;
      $display("FAIL dis_setup: got in_val3=%b irq=%b, want 1 0", in_val[3], irq);
    end
    in_en[3] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pad_dc[3] = (k < 10) ? 1'bx : 1'b0;
      tick();
      total++;
      if (in_val[3] !== 1'b1 || irq !== 1'b0) begin
        bad++;
        $display("FAIL dis_hold: cycle %0d got in_val3=%b irq=%b, want 1 0", k, in_val[3], irq);
      end
    end
    in_en[3] = 1'b1;
    pad_dc[3] = 1'b0;
    edges = 0;
    while (in_val[3] !== 1'b0 && edges < 30) begin
      tick();
      edges++;
    end
    total++;
    if (edges != 5 || irq_pend[3] !== 1'b1) begin
      bad++;
      $display("FAIL dis_reenable: got %0d edges pend3=%b, want 5 1", edges, irq_pend[3]);
    end
  endtask

  task automatic test_random();
    int errs;
    apply_reset();
    model_clear();
    errs = 0;
    db_len = 8'd3; in_en = '1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_val = N'($urandom); out_en = N'($urandom);
      pull_up = N'($urandom); pull_down = N'($urandom);
      if ($urandom_range(0, 15) == 0) in_en = N'($urandom) | N'($urandom);
      if ($urandom_range(0, 199) == 0) db_len = DBW'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0) irq_rise_en = N'($urandom);
      if ($urandom_range(0, 31) == 0) irq_fall_en = N'($urandom);
      irq_clr = N'($urandom) & N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) pad_dc[i] = ~pad_dc[i];
      rstn = (cyc == 1500) ? 1'b0 : 1'b1;
      tick();
      rstn = 1'b1;
      total++;
      if ({pad_di, pad_oe, pad_ie, pad_pu, pad_pd} !== {m_di, m_oe, m_ie, m_pu, m_pd}) begin
        bad++;
        if (errs++ < 10)
          $display("FAIL rand_pads: cyc %0d got %h %h %h %h %h, want %h %h %h %h %h", cyc,
                   pad_di, pad_oe, pad_ie, pad_pu, pad_pd, m_di, m_oe, m_ie, m_pu, m_pd);
      end
      total++;
      if (in_val !== m_lvl || irq_pend !== m_pend || irq !== (|m_pend)) begin
        bad++;
        if (errs++ < 10)
          $display("FAIL rand_input: cyc %0d got in=%h pend=%h irq=%b, want in=%h pend=%h irq=%b", cyc,
                   in_val, irq_pend, irq, m_lvl, m_pend, |m_pend);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_pull_drive();
    test_debounce();
    test_db_zero();
    test_irq_clear();
    test_in_disable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
